// File: rtl/mfc_arbiter.sv
// Round-robin sequencer sharing one 16-bit comparator (fixed priority when MFC_ARB_FIXED_PRIO_EN is defined).
// Latency: grant at E0, done/res_* after E_SETTLE; no backpressure, requesters hold req until done.
module mfc_arbiter #(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  a_in,
  input  logic [16*N_REQ-1:0]  b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 res_eq,
  output logic                 res_ae,
  output logic                 res_gt,
  output logic [3:0]           res_d,
  output logic [15:0]          cmp_a,
  output logic [15:0]          cmp_b,
  input  logic                 cmp_eq,
  input  logic                 cmp_ae,
  input  logic                 cmp_gt,
  input  logic [3:0]           cmp_d
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW = $clog2(SETTLE_EFF + 1);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          launch;
  logic          capture;

`ifdef MFC_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // Offsets scanned from farthest to nearest so pointer+1 has the highest priority.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= IW'(N_REQ - 1);
    else if (launch) ptr <= win_idx;
  end
`endif

  assign launch  = (state == IDLE) && win_vld;
  assign capture = (state == WAIT) && (cnt == CW'(1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = WAIT;
      WAIT:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      cmp_a  <= '0;
      cmp_b  <= '0;
      res_eq <= 1'b0;
      res_ae <= 1'b0;
      res_gt <= 1'b0;
      res_d  <= '0;
    end else begin
      if (launch) begin
        cmp_a <= a_in[{win_idx, 4'b0000} +: 16];
        cmp_b <= b_in[{win_idx, 4'b0000} +: 16];
        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        cnt   <= CW'(SETTLE_EFF);
      end
      if (state == WAIT) cnt <= cnt - CW'(1);
      // gnt still holds the winner's one-hot, so it becomes the done pulse.
      if (capture) begin
        res_eq <= cmp_eq;
        res_ae <= cmp_ae;
        res_gt <= cmp_gt;
        res_d  <= cmp_d;
        done   <= gnt;
        gnt    <= '0;
      end
      if (state == DONE) done <= '0;
    end
  end

endmodule
